// File: rtl/warp_ctx_manager_if.sv
// warp_ctx_manager_if: launch/issue/writeback/barrier/exit requests into the warp
// context store and the per-warp context it publishes to the scheduler.
interface warp_ctx_manager_if #(
  parameter int NUM_WARPS     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int WARP_SIZE     = 32,
  parameter int WARP_ID_WIDTH = 3,
  parameter int AGE_WIDTH     = 8
);
  logic                                  launch_valid;
  logic                                  launch_ready;
  logic [DATA_WIDTH-1:0]                 launch_pc;
  logic [WARP_SIZE-1:0]                  launch_mask;
  logic [WARP_ID_WIDTH-1:0]              launch_warp_id;
  logic                                  issue_ack;
  logic [WARP_ID_WIDTH-1:0]              issue_warp_id;
  logic                                  upd_valid;
  logic [WARP_ID_WIDTH-1:0]              upd_warp_id;
  logic [DATA_WIDTH-1:0]                 upd_pc;
  logic [WARP_SIZE-1:0]                  upd_mask;
  logic                                  bar_valid;
  logic [WARP_ID_WIDTH-1:0]              bar_warp_id;
  logic                                  exit_valid;
  logic [WARP_ID_WIDTH-1:0]              exit_warp_id;
  logic                                  kernel_clear;
  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0]  ctx_pc;
  logic [NUM_WARPS-1:0][WARP_SIZE-1:0]   ctx_mask;
  logic [NUM_WARPS-1:0][2:0]             ctx_status;
  logic [NUM_WARPS-1:0][AGE_WIDTH-1:0]   ctx_age;
  logic [NUM_WARPS-1:0]                  ctx_valid;
  logic                                  bar_release;
  logic                                  bar_timeout;

  modport master (
    output launch_valid, launch_pc, launch_mask, issue_ack, issue_warp_id,
           upd_valid, upd_warp_id, upd_pc, upd_mask, bar_valid, bar_warp_id,
           exit_valid, exit_warp_id, kernel_clear,
    input  launch_ready, launch_warp_id, ctx_pc, ctx_mask, ctx_status, ctx_age,
           ctx_valid, bar_release, bar_timeout
  );

  modport slave (
    input  launch_valid, launch_pc, launch_mask, issue_ack, issue_warp_id,
           upd_valid, upd_warp_id, upd_pc, upd_mask, bar_valid, bar_warp_id,
           exit_valid, exit_warp_id, kernel_clear,
    output launch_ready, launch_warp_id, ctx_pc, ctx_mask, ctx_status, ctx_age,
           ctx_valid, bar_release, bar_timeout
  );
endinterface

// File: rtl/warp_ctx_manager.sv
// warp_ctx_manager: per-core warp context store and lifecycle controller.
// Barrier watchdog is built only when WARP_CTX_BAR_WATCHDOG_EN is defined.
module warp_ctx_manager #(
  parameter int NUM_WARPS     = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int WARP_SIZE     = 32,
  parameter int WARP_ID_WIDTH = 3,
  parameter int AGE_WIDTH     = 8,
  parameter int BAR_TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  warp_ctx_manager_if.slave bus
);
  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_READY   = 3'd1,
    WARP_BARRIER = 3'd2,
    WARP_DONE    = 3'd3
  } warp_status_t;

  localparam int CNT_W = $clog2(NUM_WARPS + 1);

  logic [NUM_WARPS-1:0][DATA_WIDTH-1:0] pc_r, pc_s;
  logic [NUM_WARPS-1:0][WARP_SIZE-1:0]  mask_r, mask_s;
  logic [NUM_WARPS-1:0][2:0]            status_r, status_s;
  logic [NUM_WARPS-1:0][AGE_WIDTH-1:0]  age_r, age_s;
  logic [NUM_WARPS-1:0]                 valid_r, valid_s;
  logic                                 bar_release_r;
  logic                                 launch_ready_s;
  logic                                 launch_fire_s;
  logic [WARP_ID_WIDTH-1:0]             free_id_s;
  logic [CNT_W-1:0]                     bar_cnt_s;
  logic [CNT_W-1:0]                     act_cnt_s;
  logic                                 release_s;

  // An ID outside the slot range never matches any slot, so it is ignored.
  function automatic logic id_hit(input logic v, input logic [WARP_ID_WIDTH-1:0] id,
                                  input int w);
    return v && (32'(id) == 32'(w));
  endfunction

  // Lowest free slot index; 0 when every slot is occupied.
  always_comb begin
    free_id_s = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (!valid_r[w]) free_id_s = WARP_ID_WIDTH'(w);
      else             free_id_s = free_id_s;
    end
  end

  assign launch_ready_s = (|(~valid_r)) && !bus.kernel_clear;
  assign launch_fire_s  = bus.launch_valid && launch_ready_s;

  // Barrier and live-warp population counts from registered state.
  always_comb begin
    bar_cnt_s = '0;
    act_cnt_s = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (valid_r[w] && status_r[w] != WARP_DONE) act_cnt_s = act_cnt_s + CNT_W'(1);
      else                                        act_cnt_s = act_cnt_s;
      if (valid_r[w] && status_r[w] == WARP_BARRIER) bar_cnt_s = bar_cnt_s + CNT_W'(1);
      else                                           bar_cnt_s = bar_cnt_s;
    end
  end

  assign release_s = (bar_cnt_s != '0) && (bar_cnt_s == act_cnt_s) && !bus.kernel_clear;

  // Next-state context: clear > launch > exit > barrier > writeback, age independent.
  always_comb begin
    pc_s     = pc_r;
    mask_s   = mask_r;
    status_s = status_r;
    age_s    = age_r;
    valid_s  = valid_r;
    if (bus.kernel_clear) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pc_s[w]     = '0;
        mask_s[w]   = '0;
        status_s[w] = WARP_IDLE;
        age_s[w]    = '0;
        valid_s[w]  = 1'b0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (launch_fire_s && (32'(free_id_s) == 32'(w))) begin
          valid_s[w]  = 1'b1;
          status_s[w] = WARP_READY;
          pc_s[w]     = bus.launch_pc;
          mask_s[w]   = bus.launch_mask;
          age_s[w]    = '0;
        end else if (valid_r[w]) begin
          if (id_hit(bus.exit_valid, bus.exit_warp_id, w)) begin
            status_s[w] = WARP_DONE;
          end else if (id_hit(bus.bar_valid, bus.bar_warp_id, w)) begin
            if (status_r[w] == WARP_READY) status_s[w] = WARP_BARRIER;
            else                           status_s[w] = status_r[w];
          end else if (id_hit(bus.upd_valid, bus.upd_warp_id, w) &&
                       status_r[w] != WARP_DONE) begin
            pc_s[w]   = bus.upd_pc;
            mask_s[w] = bus.upd_mask;
          end else begin
            status_s[w] = status_r[w];
          end
          // Arrivals land first, so a same-cycle arrival joins the released group.
          if (release_s && status_s[w] == WARP_BARRIER) status_s[w] = WARP_READY;
          else                                          status_s[w] = status_s[w];
          if (id_hit(bus.issue_ack, bus.issue_warp_id, w)) begin
            age_s[w] = '0;
          end else if (status_r[w] == WARP_READY && age_r[w] != {AGE_WIDTH{1'b1}}) begin
            age_s[w] = age_r[w] + AGE_WIDTH'(1);
          end else begin
            age_s[w] = age_r[w];
          end
        end else begin
          valid_s[w] = 1'b0;
        end
      end
    end
  end

  // Context and barrier-release registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= '0;
      mask_r        <= '0;
      status_r      <= '0;
      age_r         <= '0;
      valid_r       <= '0;
      bar_release_r <= 1'b0;
    end else begin
      pc_r          <= pc_s;
      mask_r        <= mask_s;
      status_r      <= status_s;
      age_r         <= age_s;
      valid_r       <= valid_s;
      bar_release_r <= release_s;
    end
  end

  assign bus.launch_ready   = launch_ready_s;
  assign bus.launch_warp_id = free_id_s;
  assign bus.ctx_pc         = pc_r;
  assign bus.ctx_mask       = mask_r;
  assign bus.ctx_status     = status_r;
  assign bus.ctx_age        = age_r;
  assign bus.ctx_valid      = valid_r;
  assign bus.bar_release    = bar_release_r;

`ifdef WARP_CTX_BAR_WATCHDOG_EN
  localparam int WD_W = $clog2(BAR_TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt_r;
  logic            bar_timeout_r;

  // Watchdog: counts while any warp waits at a barrier; timeout is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_r      <= '0;
      bar_timeout_r <= 1'b0;
    end else if (bus.kernel_clear) begin
      wd_cnt_r      <= '0;
      bar_timeout_r <= 1'b0;
    end else begin
      if (bar_release_r || bar_cnt_s == '0)     wd_cnt_r <= '0;
      else if (wd_cnt_r != WD_W'(BAR_TIMEOUT)) wd_cnt_r <= wd_cnt_r + WD_W'(1);
      else                                     wd_cnt_r <= wd_cnt_r;
      if (wd_cnt_r == WD_W'(BAR_TIMEOUT)) bar_timeout_r <= 1'b1;
      else                                bar_timeout_r <= bar_timeout_r;
    end
  end

  assign bus.bar_timeout = bar_timeout_r;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^BAR_TIMEOUT;
  assign bus.bar_timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_warp_ctx_manager.sv
// tb_warp_ctx_manager: table-driven directed checks of the warp context store
// plus hand-written age-saturation and asynchronous-reset sequences.
module tb_warp_ctx_manager;
  localparam int NW = 4;
  localparam logic [2:0] SI = 3'd0, SR = 3'd1, SB = 3'd2, SD = 3'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  warp_ctx_manager_if #(.NUM_WARPS(NW), .DATA_WIDTH(32), .WARP_SIZE(32),
                        .WARP_ID_WIDTH(3), .AGE_WIDTH(8)) bus ();

  warp_ctx_manager #(.NUM_WARPS(NW), .DATA_WIDTH(32), .WARP_SIZE(32),
                     .WARP_ID_WIDTH(3), .AGE_WIDTH(8), .BAR_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        lv;  logic [31:0] lpc;
    logic        uv;  logic [2:0]  uid; logic [31:0] upc;
    logic        bv;  logic [2:0]  bid;
    logic        ev;  logic [2:0]  eid;
    logic        kc;
    logic        e_ready; logic [2:0] e_wid;
    logic [3:0]  e_valid; logic [11:0] e_status;
    logic        pc_en; int pc_w; logic [31:0] e_pc;
    logic        e_rel;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [11:0] st(input logic [2:0] s3, input logic [2:0] s2,
                                     input logic [2:0] s1, input logic [2:0] s0);
    return {s3, s2, s1, s0};
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.launch_valid = 1'b0; bus.launch_pc = '0; bus.launch_mask = '0;
    bus.issue_ack = 1'b0; bus.issue_warp_id = '0;
    bus.upd_valid = 1'b0; bus.upd_warp_id = '0; bus.upd_pc = '0; bus.upd_mask = '0;
    bus.bar_valid = 1'b0; bus.bar_warp_id = '0;
    bus.exit_valid = 1'b0; bus.exit_warp_id = '0;
    bus.kernel_clear = 1'b0;
  endtask

  initial begin
    // lv lpc | uv uid upc | bv bid | ev eid | kc || ready wid valid status pc_en pc_w pc rel
    tbl[0]  = '{1'b1, 32'h100, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd0, 4'b0001, st(SI, SI, SI, SR), 1'b1, 0, 32'h100, 1'b0};
    tbl[1]  = '{1'b1, 32'h110, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd1, 4'b0011, st(SI, SI, SR, SR), 1'b1, 1, 32'h110, 1'b0};
    tbl[2]  = '{1'b1, 32'h120, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd2, 4'b0111, st(SI, SR, SR, SR), 1'b1, 2, 32'h120, 1'b0};
    tbl[3]  = '{1'b1, 32'h130, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd3, 4'b1111, st(SR, SR, SR, SR), 1'b1, 3, 32'h130, 1'b0};
    tbl[4]  = '{1'b1, 32'h140, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SR, SR, SR), 1'b1, 0, 32'h100, 1'b0};
    tbl[5]  = '{1'b1, 32'h140, 1'b1, 3'd1, 32'h200, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SR, SR, SR), 1'b1, 1, 32'h200, 1'b0};
    tbl[6]  = '{1'b0, 32'h0, 1'b1, 3'd5, 32'h777, 1'b0, 3'd0, 1'b1, 3'd6, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SR, SR, SR), 1'b1, 1, 32'h200, 1'b0};
    tbl[7]  = '{1'b0, 32'h0, 1'b1, 3'd2, 32'h500, 1'b0, 3'd0, 1'b1, 3'd2, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SD, SR, SR), 1'b1, 2, 32'h120, 1'b0};
    tbl[8]  = '{1'b0, 32'h0, 1'b1, 3'd2, 32'h600, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SD, SR, SR), 1'b1, 2, 32'h120, 1'b0};
    tbl[9]  = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SD, SR, SB), 1'b0, 0, 32'h0, 1'b0};
    tbl[10] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SR, SD, SB, SB), 1'b0, 0, 32'h0, 1'b0};
    tbl[11] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SD, SD, SB, SB), 1'b0, 0, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SD, SD, SR, SR), 1'b0, 0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b0, 3'd0, 4'b1111, st(SD, SD, SR, SR), 1'b0, 0, 32'h0, 1'b0};
    tbl[14] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1,
                1'b0, 3'd0, 4'b0000, st(SI, SI, SI, SI), 1'b0, 0, 32'h0, 1'b0};
    tbl[15] = '{1'b1, 32'h300, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd0, 4'b0001, st(SI, SI, SI, SR), 1'b1, 0, 32'h300, 1'b0};
    tbl[16] = '{1'b1, 32'h310, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1,
                1'b0, 3'd1, 4'b0000, st(SI, SI, SI, SI), 1'b0, 0, 32'h0, 1'b0};
    tbl[17] = '{1'b0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0,
                1'b1, 3'd0, 4'b0000, st(SI, SI, SI, SI), 1'b0, 0, 32'h0, 1'b0};

    idle_inputs();
    repeat (3) @(negedge clk);
    check("reset_valid", 0, 64'(bus.ctx_valid), 64'h0);
    check("reset_status", 0, 64'(bus.ctx_status), 64'h0);
    check("reset_pc", 0, 64'(bus.ctx_pc[0]), 64'h0);
    check("reset_release", 0, 64'(bus.bar_release), 64'h0);
    check("reset_timeout", 0, 64'(bus.bar_timeout), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      idle_inputs();
      bus.launch_valid = tbl[i].lv;  bus.launch_pc = tbl[i].lpc;
      bus.launch_mask  = 32'hFFFF_FFFF;
      bus.upd_valid    = tbl[i].uv;  bus.upd_warp_id = tbl[i].uid;
      bus.upd_pc       = tbl[i].upc; bus.upd_mask = 32'h0000_00FF;
      bus.bar_valid    = tbl[i].bv;  bus.bar_warp_id = tbl[i].bid;
      bus.exit_valid   = tbl[i].ev;  bus.exit_warp_id = tbl[i].eid;
      bus.kernel_clear = tbl[i].kc;
      #1;
      check("launch_ready", i, 64'(bus.launch_ready), 64'(tbl[i].e_ready));
      check("launch_warp_id", i, 64'(bus.launch_warp_id), 64'(tbl[i].e_wid));
      @(negedge clk);
      check("ctx_valid", i, 64'(bus.ctx_valid), 64'(tbl[i].e_valid));
      check("ctx_status", i, 64'(bus.ctx_status), 64'(tbl[i].e_status));
      check("bar_release", i, 64'(bus.bar_release), 64'(tbl[i].e_rel));
      if (tbl[i].pc_en) check("ctx_pc", i, 64'(bus.ctx_pc[tbl[i].pc_w]), 64'(tbl[i].e_pc));
    end

    // Age: fill all four slots back to back, then issue warp 1 every cycle.
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.launch_valid = 1'b1;
      bus.launch_pc    = 32'h400 + 32'(i);
      bus.launch_mask  = 32'h1 << i;
      @(negedge clk);
    end
    idle_inputs();
    check("age_w0_after_fill", 0, 64'(bus.ctx_age[0]), 64'd3);
    check("age_w3_after_fill", 0, 64'(bus.ctx_age[3]), 64'd0);
    check("mask_w2", 0, 64'(bus.ctx_mask[2]), 64'h4);
    bus.issue_ack     = 1'b1;
    bus.issue_warp_id = 3'd1;
    repeat (300) @(negedge clk);
    check("age_w1_issued", 0, 64'(bus.ctx_age[1]), 64'd0);
    check("age_w0_sat", 0, 64'(bus.ctx_age[0]), 64'd255);
    check("age_w2_sat", 0, 64'(bus.ctx_age[2]), 64'd255);
    check("age_w3_sat", 0, 64'(bus.ctx_age[3]), 64'd255);
    check("timeout_tied", 0, 64'(bus.bar_timeout), 64'h0);

    // Asynchronous reset mid-operation discards contexts without a clock edge.
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 0, 64'(bus.ctx_valid), 64'h0);
    check("async_rst_age", 0, 64'(bus.ctx_age[0]), 64'h0);
    check("async_rst_ready", 0, 64'(bus.launch_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
